// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports, the shared read-return bus and the memory strobe side
// of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic              p0_err;
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic              p1_err;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_err,
    output p1_gnt, p1_rvalid, p1_err,
    output rdata, busy,
    output mem_read, mem_write, mem_rd_addr, mem_wr_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_err,
    input  p1_gnt, p1_rvalid, p1_err,
    input  rdata, busy,
    input  mem_read, mem_write, mem_rd_addr, mem_wr_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the byte-pair data memory: one access in
// flight, registered strobes, odd addresses rejected without touching memory.
module dmem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, ERR} state_t;

  state_t            r_state;
  logic              r_last;
  logic              r_cur;
  logic              r_we;
  logic [1:0]        r_gnt;
  logic [1:0]        r_err;
  logic [1:0]        r_rvalid;
  logic              r_busy;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_any;
  logic              w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    w_any = bus.p0_req | bus.p1_req;
    w_win = (bus.p0_req && bus.p1_req) ? ~r_last : ~bus.p0_req;
    w_we    = w_win ? bus.p1_we    : bus.p0_we;
    w_addr  = w_win ? bus.p1_addr  : bus.p0_addr;
    w_wdata = w_win ? bus.p1_wdata : bus.p0_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_cur       <= 1'b0;
      r_we        <= 1'b0;
      r_gnt       <= '0;
      r_err       <= '0;
      r_rvalid    <= '0;
      r_busy      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wdata     <= '0;
    end else begin
      r_gnt       <= '0;
      r_err       <= '0;
      r_rvalid    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last <= w_win;
            r_cur  <= w_win;
            r_we   <= w_we;
            r_busy <= 1'b1;
            if (w_addr[0]) begin
              r_state        <= ERR;
              r_err[w_win]   <= 1'b1;
            end else begin
              r_state        <= ACCESS;
              r_gnt[w_win]   <= 1'b1;
              if (w_we) begin
                r_mem_write <= 1'b1;
                r_wr_addr   <= w_addr;
                r_wdata     <= w_wdata;
              end else begin
                r_mem_read  <= 1'b1;
                r_rd_addr   <= w_addr;
              end
            end
          end
        end
        ACCESS: begin
          if (r_we) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state         <= RDATA;
            r_rvalid[r_cur] <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p0_gnt      = r_gnt[0];
  assign bus.p1_gnt      = r_gnt[1];
  assign bus.p0_err      = r_err[0];
  assign bus.p1_err      = r_err[1];
  assign bus.p0_rvalid   = r_rvalid[0];
  assign bus.p1_rvalid   = r_rvalid[1];
  assign bus.busy        = r_busy;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_rd_addr = r_rd_addr;
  assign bus.mem_wr_addr = r_wr_addr;
  assign bus.mem_wdata   = r_wdata;
  // Memory output is passed straight through, but only while a read return is flagged.
  assign bus.rdata       = (r_rvalid != 2'b00) ? bus.mem_rdata : '0;
endmodule
